// File: rtl/sync_fifo_pkg.sv
// sync_fifo_ext shared definitions.
// Count width helper and read-mode selectors.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_ext handshake and status bundle.
// master = producer/consumer side, slave = FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);

  localparam int CW = cnt_w(2 ** ADDR_WIDTH);

  logic                  Write_EN;
  logic                  Read_EN;
  logic                  Flag_Clr;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  Full;
  logic                  Empty;
  logic                  AlmostFull;
  logic                  AlmostEmpty;
  logic [CW-1:0]         Count;
  logic                  Overflow;
  logic                  Underflow;

  modport master (
    output Write_EN, Read_EN, Flag_Clr, DataIn,
    input  DataOut, Full, Empty, AlmostFull,
    input  AlmostEmpty, Count, Overflow, Underflow
  );

  modport slave (
    input  Write_EN, Read_EN, Flag_Clr, DataIn,
    output DataOut, Full, Empty, AlmostFull,
    output AlmostEmpty, Count, Overflow, Underflow
  );

endinterface

// File: rtl/sync_fifo_ext_ram.sv
// Simple dual-port storage: sync write, async read.
// Async read lets FWFT present the head word with no latency.
module fifo_ram #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2 ** AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with thresholds, occupancy count,
// sticky error flags and registered/FWFT read modes.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = FIFO_STD
) (
  input  logic      clk,
  input  logic      rst_n,
  sync_fifo_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = cnt_w(DEPTH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("AE_THRESH out of range 0..DEPTH-1");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("FWFT must be 0 or 1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf;
  logic                  udf;

  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;
  assign wr_acc = bus.Write_EN && !full;
  assign rd_acc = bus.Read_EN && !empty;

  fifo_ram #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && rst_n),
    .waddr (wr_ptr),
    .wdata (bus.DataIn),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      dout_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // a new error in the clear cycle keeps the flag set
      if (bus.Write_EN && full)      ovf <= 1'b1;
      else if (bus.Flag_Clr)         ovf <= 1'b0;
      if (bus.Read_EN && empty)      udf <= 1'b1;
      else if (bus.Flag_Clr)         udf <= 1'b0;
      if (rd_acc && FWFT == FIFO_STD) dout_q <= rdata;
    end
  end

  assign bus.Full        = full;
  assign bus.Empty       = empty;
  assign bus.AlmostFull  = count >= CW'(AF_THRESH);
  assign bus.AlmostEmpty = count <= CW'(AE_THRESH);
  assign bus.Count       = count;
  assign bus.Overflow    = ovf;
  assign bus.Underflow   = udf;
  assign bus.DataOut     = (FWFT == FIFO_FWFT && !empty)
                         ? rdata : dout_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench for sync_fifo_ext: one registered-read and
// one FWFT instance driven in lockstep against a queue model.
module tb_sync_fifo_ext;

  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int AE    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] din = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) f0 ();
  sync_fifo_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) f1 ();

  assign f0.Write_EN = we;
  assign f0.Read_EN  = re;
  assign f0.Flag_Clr = clr;
  assign f0.DataIn   = din;
  assign f1.Write_EN = we;
  assign f1.Read_EN  = re;
  assign f1.Flag_Clr = clr;
  assign f1.DataIn   = din;

  sync_fifo_ext #(
    .ADDR_WIDTH(5), .DATA_WIDTH(16),
    .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .bus(f0.slave)
  );

  sync_fifo_ext #(
    .ADDR_WIDTH(5), .DATA_WIDTH(16),
    .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(f1.slave)
  );

  // reference model: contents as a plain queue
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  logic [15:0] dout0 = '0;
  logic [15:0] front;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic        pend = 1'b0;
  logic        started = 1'b0;
  logic        wa;
  logic        ra;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      dout0 = '0;
      pend = 1'b0;
      started = 1'b1;
    end else begin
      wa = we && (mq.size() < DEPTH);
      ra = re && (mq.size() > 0);
      if (ra) begin
        front = mq.pop_front();
        dout0 = front;
        exp_q.push_back(front);
        pend = 1'b1;
      end
      if (wa) mq.push_back(din);
      if (we && !wa) m_ovf = 1'b1;
      else if (clr)  m_ovf = 1'b0;
      if (re && !ra) m_udf = 1'b1;
      else if (clr)  m_udf = 1'b0;
    end
  end

  task automatic chk(input string n, input longint a,
                     input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic chk_flags(input string n,
                           input logic [5:0] c,
                           input logic fu, input logic em,
                           input logic af, input logic ae,
                           input logic ov, input logic ud);
    int sz;
    sz = mq.size();
    chk({n, "_count"}, c, sz);
    chk({n, "_full"},  fu, sz == DEPTH);
    chk({n, "_empty"}, em, sz == 0);
    chk({n, "_afull"}, af, sz >= AF);
    chk({n, "_aempty"}, ae, sz <= AE);
    chk({n, "_ovf"},   ov, m_ovf);
    chk({n, "_udf"},   ud, m_udf);
  endtask

  // monitor: outputs are registered, so negedge is race free
  always @(negedge clk) begin
    if (started) begin
      chk_flags("std", f0.Count, f0.Full, f0.Empty,
                f0.AlmostFull, f0.AlmostEmpty,
                f0.Overflow, f0.Underflow);
      chk_flags("fwft", f1.Count, f1.Full, f1.Empty,
                f1.AlmostFull, f1.AlmostEmpty,
                f1.Overflow, f1.Underflow);
      if (pend) begin
        chk("std_rdata", f0.DataOut, exp_q.pop_front());
        pend = 1'b0;
      end else begin
        chk("std_hold", f0.DataOut, dout0);
      end
      if (mq.size() > 0)
        chk("fwft_head", f1.DataOut, mq[0]);
    end
  end

  task automatic cyc(input logic w, input logic r,
                     input logic c, input logic [15:0] d);
    @(negedge clk);
    we = w;
    re = r;
    clr = c;
    din = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    we = 1'b0;
    re = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // fill, with one write beyond full
    for (int i = 1; i <= 33; i++) cyc(1, 0, 0, 16'(i));
    // drain, with one read beyond empty
    for (int i = 0; i < 33; i++) cyc(0, 1, 0, '0);
    cyc(0, 0, 1, '0);
    // FWFT visibility without a pop, then pop
    cyc(1, 0, 0, 16'hA5A5);
    cyc(0, 0, 0, '0);
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
    // simultaneous traffic at Count=10
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 16'(100 + i));
    for (int i = 0; i < 50; i++)
      cyc(1, 1, 0, 16'($urandom));
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, '0);
    // both at full: read wins, write overflows
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 16'($urandom));
    cyc(1, 1, 0, 16'hDEAD);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
    // mid-operation reset at Count=17
    do_reset();
    cyc(1, 0, 0, 16'h1234);
    cyc(1, 0, 0, 16'h5678);
    cyc(0, 1, 0, '0);
    cyc(0, 1, 0, '0);
    // overflow pending, clear with set-wins, then clear
    for (int i = 0; i < 33; i++) cyc(1, 0, 0, 16'($urandom));
    cyc(1, 0, 1, '0);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    for (int i = 0; i < 33; i++) cyc(0, 1, 0, '0);
    cyc(0, 1, 1, '0);
    cyc(0, 0, 1, '0);
    // randomized traffic at several fill biases
    for (int ph = 0; ph < 4; ph++) begin
      int pw;
      int pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 55 : 50;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 45 : 50;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else begin
          cyc($urandom_range(0, 99) < pw,
              $urandom_range(0, 99) < pr,
              $urandom_range(0, 19) == 0,
              16'($urandom));
        end
      end
    end
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    @(negedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO. It is the successor to the basic synchronous FIFO and adds:
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow error flags;
- a selectable read mode: standard registered read, or first-word-fall-through (FWFT).

It sits between any producer/consumer pair in the same clock domain and is the default buffering block for new datapaths.

## Interface
Parameters:
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 16, word width
- AF_THRESH, DEPTH-4, AlmostFull asserts when Count >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 4, AlmostEmpty asserts when Count <= AE_THRESH; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- Write_EN  in  1  write request
- Read_EN  in  1  read request
- Flag_Clr  in  1  clears Overflow and Underflow
- DataIn  in  DATA_WIDTH  write data
- DataOut  out  DATA_WIDTH  read data
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- AlmostFull  out  1  Count >= AF_THRESH
- AlmostEmpty  out  1  Count <= AE_THRESH
- Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- Overflow  out  1  sticky; a write was attempted while Full
- Underflow  out  1  sticky; a read was attempted while Empty

## Operation
- Accepted write: Write_EN && !Full. DataIn is stored at wr_ptr, then wr_ptr increments.
- Accepted read: Read_EN && !Empty. rd_ptr increments.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Count is a registered counter:
  - +1 on write only;
  - -1 on read only;
  - unchanged when both or neither are accepted.
- Simultaneous write and read:
  - when neither Full nor Empty, both are accepted and Count holds;
  - when Full, only the read is accepted and the write is rejected;
  - when Empty, only the write is accepted and the read is rejected.
- All status flags decode from the registered Count only; there is no combinational path from any input to any flag.
- Rejected write sets Overflow. Rejected read sets Underflow. Memory, pointers and Count are unaffected by a rejected request.
- Sticky flags clear only on reset or Flag_Clr. If Flag_Clr and a new error occur in the same cycle, the flag stays set (set wins).
- FWFT=0: DataOut is a register loaded with mem[rd_ptr] on an accepted read. It holds its value otherwise, including on a rejected read.
- FWFT=1: DataOut = mem[rd_ptr] whenever !Empty, and Read_EN acts as a pop. DataOut is don't-care while Empty; the bench must not check it then.
- Threshold parameters outside their legal range fail elaboration via an assertion.

## Timing
- Reset (rst_n low at a rising edge) forces:
  - wr_ptr = 0, rd_ptr = 0, Count = 0;
  - Empty = 1, AlmostEmpty = 1, Full = 0, AlmostFull = 0;
  - Overflow = 0, Underflow = 0;
  - DataOut = 0.
- Memory contents are not reset.
- Reset mid-operation discards all stored words; the first accepted write after reset lands at address 0.
- Write to read visibility: a write accepted at edge N deasserts Empty after edge N.
  - FWFT=1: the word is on DataOut in cycle N+1.
  - FWFT=0: the earliest read is accepted at edge N+1, and its data appears after edge N+1.
- Read latency:
  - FWFT=0: one cycle from the accepting edge;
  - FWFT=1: zero (data is already presented before the pop).
- Flags and Count update on the same edge that accepts the operation.
- Full and Empty are never asserted together.
- Throughput is one write and one read per cycle sustained.

## Structure
- Package sync_fifo_pkg holds:
  - the count-width function clog2(DEPTH)+1;
  - the read-mode constants FIFO_STD = 0 and FIFO_FWFT = 1.
- Sub-module fifo_ram: simple dual-port array.
  - One synchronous write port.
  - One asynchronous read port; FWFT mode requires it.
  - The FWFT=0 output register sits in the top level, not in the RAM.
- The top level contains pointers, the counter, flag decode, sticky error logic and the read-mode mux.

## Test plan
Parameters for all scenarios: ADDR_WIDTH=5, DATA_WIDTH=16, AF_THRESH=28, AE_THRESH=4.
- Fill, FWFT=0: write 1..32 on consecutive cycles.
  - AlmostEmpty drops when Count reaches 5.
  - AlmostFull rises when Count reaches 28.
  - Full rises when Count reaches 32.
  - A 33rd write sets Overflow, and Count stays 32.
- Drain, FWFT=0: read 33 times from full. DataOut is 1..32, each one cycle after its read edge. Empty rises on the 32nd read. The 33rd read sets Underflow, and DataOut holds 32.
- FWFT=1: write 0xA5A5 into an empty FIFO. DataOut = 0xA5A5 and Empty = 0 the next cycle, with no Read_EN. A pop returns Empty to 1.
- Simultaneous operations:
  - At Count=10, Write_EN and Read_EN together for 50 cycles: Count stays 10 and the output order is preserved.
  - At Full, both together: the read is accepted, the write is rejected, Count becomes 31 and Overflow = 1.
- Mid-operation reset at Count=17, then Flag_Clr.
  - After reset: Count = 0, Empty = 1, Overflow = 0, Underflow = 0, DataOut = 0.
  - The next written word 0x1234 is read back first.
  - Flag_Clr pulsed with an Overflow pending clears it in one cycle.
